// File: rtl/route_ctrl_pkg.sv
// Shared constants for the route-layer read sequencer: FSM state codes,
// inter-row gap length and default widths.
package route_ctrl_pkg;

  localparam int WIDTH_DEF     = 128;
  localparam int ADDR_BITS_DEF = 10;
  localparam int CNT_BITS_DEF  = 12;

  localparam int GAP_CYCLES = 2;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_HOLD = 2'd2;
  localparam logic [1:0] F_END  = 2'd3;

  localparam logic [2:0] B_IDLE = 3'd0;
  localparam logic [2:0] B_WAIT = 3'd1;
  localparam logic [2:0] B_READ = 3'd2;
  localparam logic [2:0] B_GAP  = 3'd3;
  localparam logic [2:0] B_DONE = 3'd4;

endpackage

// File: rtl/route_req_gen.sv
// Front FSM: issues one read request per row to the memory reader while the
// FIFO reports room, until row_num requests have been handshaken.
module route_req_gen
  import route_ctrl_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                finish_i,
  input  logic [CNT_BITS-1:0] row_num_i,
  input  logic                s_ready_i,
  input  logic                req_ready_i,
  output logic                req_valid_o
);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] req_cnt_q, req_cnt_d;

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    case (state_q)
      F_IDLE: begin
        if (start_i) begin
          state_d   = F_REQ;
          req_cnt_d = '0;
        end
      end
      F_REQ: begin
        if (req_cnt_q == row_num_i) state_d = F_END;
        else if (s_ready_i)         state_d = F_HOLD;
      end
      F_HOLD: begin
        // req_valid stays up regardless of S_Ready until the reader takes it
        if (req_ready_i) begin
          req_cnt_d = req_cnt_q + 1'b1;
          state_d   = (req_cnt_d == row_num_i) ? F_END : F_REQ;
        end
      end
      F_END:   state_d = F_END;
      default: state_d = F_IDLE;
    endcase
    if (finish_i) state_d = F_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= F_IDLE;
      req_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  assign req_valid_o = (state_q == F_HOLD);

endmodule

// File: rtl/route_read_ctrl.sv
// Route-layer read sequencer: config latch, back (drain) FSM and completion.
// Optional ROUTE_READ_CTRL_ERR_EN adds a sticky err output.
module route_read_ctrl
  import route_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   row_words,
  input  logic [CNT_BITS-1:0]  row_num,
  output logic                 busy,
  output logic                 done,
  output logic                 fifo_clr,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [ADDR_BITS:0]   M_count,
  output logic [ADDR_BITS:0]   S_count,
  input  logic                 M_Ready,
  input  logic                 S_Ready,
  output logic                 fifo_rd_en,
  output logic                 dout_valid,
  output logic                 row_last
`ifdef ROUTE_READ_CTRL_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  logic [2:0]          back_q, back_d;
  logic [ADDR_BITS:0]  row_words_q, row_words_d;
  logic [CNT_BITS-1:0] row_num_q, row_num_d;
  logic [CNT_BITS-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_BITS:0]  word_cnt_q, word_cnt_d;
  logic [1:0]          gap_cnt_q, gap_cnt_d;
  logic                busy_q, done_q, fifo_clr_q, dout_valid_q, row_last_q;
  logic                start_acc, rd_en, word_last;

  assign start_acc = start & (back_q == B_IDLE);
  assign rd_en     = (back_q == B_READ);
  assign word_last = (word_cnt_q == row_words_q - 1'b1);

  always_comb begin
    back_d      = back_q;
    row_words_d = row_words_q;
    row_num_d   = row_num_q;
    row_cnt_d   = row_cnt_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (back_q)
      B_IDLE: begin
        if (start) begin
          back_d      = B_WAIT;
          row_words_d = row_words;
          row_num_d   = row_num;
          row_cnt_d   = '0;
          word_cnt_d  = '0;
`ifdef ROUTE_READ_CTRL_ERR_EN
          if (row_words == '0 || row_num == '0) back_d = B_DONE;
`endif
        end
      end
      B_WAIT: begin
        if (M_Ready) back_d = B_READ;
      end
      B_READ: begin
        if (word_last) begin
          word_cnt_d = '0;
          row_cnt_d  = row_cnt_q + 1'b1;
          gap_cnt_d  = '0;
          back_d     = (row_cnt_d == row_num_q) ? B_DONE : B_GAP;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      B_GAP: begin
        // M_Ready lags the FIFO count; give it time to drop after a row drains
        if (gap_cnt_q == GAP_LAST) back_d = B_WAIT;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      B_DONE:  back_d = B_IDLE;
      default: back_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      back_q       <= B_IDLE;
      row_words_q  <= '0;
      row_num_q    <= '0;
      row_cnt_q    <= '0;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fifo_clr_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      row_last_q   <= 1'b0;
    end else begin
      back_q       <= back_d;
      row_words_q  <= row_words_d;
      row_num_q    <= row_num_d;
      row_cnt_q    <= row_cnt_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      busy_q       <= start_acc | (busy_q & (back_q != B_DONE));
      done_q       <= (back_q == B_DONE);
      fifo_clr_q   <= start_acc;
      dout_valid_q <= rd_en;
      row_last_q   <= rd_en & word_last;
    end
  end

`ifdef ROUTE_READ_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start_acc)                     err_d = (row_words == '0) || (row_num == '0);
    else if (start)                    err_d = 1'b1;
    if (back_q == B_READ && !M_Ready)  err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  route_req_gen #(
    .CNT_BITS (CNT_BITS)
  ) u_req_gen (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_acc),
    .finish_i    (back_q == B_DONE),
    .row_num_i   (row_num_q),
    .s_ready_i   (S_Ready),
    .req_ready_i (req_ready),
    .req_valid_o (req_valid)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_clr   = fifo_clr_q;
  assign M_count    = row_words_q;
  assign S_count    = row_words_q;
  assign fifo_rd_en = rd_en;
  assign dout_valid = dout_valid_q & (WIDTH != 0);
  assign row_last   = row_last_q;

endmodule

// File: tb/tb_route_read_ctrl.sv
// Randomized bench for route_read_ctrl: FIFO/reader model plus a scoreboard of
// expected output beats and done pulses derived from row_words x row_num.
module tb_route_read_ctrl;

  localparam int AB    = 10;
  localparam int CB    = 12;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AB:0]   row_words;
  logic [CB-1:0] row_num;
  logic          busy, done, fifo_clr, req_valid, req_ready;
  logic [AB:0]   M_count, S_count;
  logic          M_Ready, S_Ready, fifo_rd_en, dout_valid, row_last;
`ifdef ROUTE_READ_CTRL_ERR_EN
  logic          err;
`endif

  route_read_ctrl #(.WIDTH(128), .ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .row_words(row_words), .row_num(row_num),
    .busy(busy), .done(done), .fifo_clr(fifo_clr), .req_valid(req_valid),
    .req_ready(req_ready), .M_count(M_count), .S_count(S_count),
    .M_Ready(M_Ready), .S_Ready(S_Ready), .fifo_rd_en(fifo_rd_en),
    .dout_valid(dout_valid), .row_last(row_last)
`ifdef ROUTE_READ_CTRL_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit is_done; bit last; int rows;} exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  int fcount = 0, pend = 0, wcnt = 0;
  int rr_mode = 0;
  bit s_hold = 0, m_toggle = 0;
  int beats = 0, hs_cnt = 0, idle = 100;
  bit p_rst = 1, p_vld = 0, p_rdy = 0, p_srdy = 0, p_dv = 0, p_last = 0, p_rd = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // FIFO + memory reader model: registered M_Ready/S_Ready, 0..1 word/cycle fill
  always @(posedge clk) begin
    int wr, rd;
    bit hs;
    hs = req_valid && req_ready;
    rd = fifo_rd_en ? 1 : 0;
    if (rst || fifo_clr) begin
      fcount    <= 0;
      pend      <= 0;
      wcnt      <= 0;
      M_Ready   <= 1'b0;
      S_Ready   <= 1'b0;
      req_ready <= (rr_mode == 0);
    end else begin
      if (rd != 0) chk("fifo_underrun", fcount == 0, 0);
      wr = (pend > 0 && $urandom_range(0, 3) != 0) ? 1 : 0;
      fcount  <= fcount + wr - rd;
      pend    <= pend + (hs ? int'(M_count) : 0) - wr;
      M_Ready <= (fcount > 0) && (fcount >= int'(M_count)) &&
                 !(m_toggle && $urandom_range(0, 2) == 0);
      S_Ready <= (fcount + pend + int'(M_count) <= DEPTH) && !s_hold;
      case (rr_mode)
        0: req_ready <= 1'b1;
        1: begin
          if (req_valid && !req_ready) begin
            wcnt <= wcnt + 1;
            if (wcnt + 1 >= 3) req_ready <= 1'b1;
          end else begin
            wcnt      <= 0;
            req_ready <= 1'b0;
          end
        end
        default: req_ready <= 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every beat / done and checks protocol rules
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_rst  = 1;
      idle   = 100;
      hs_cnt = 0;
    end else begin
      if (dout_valid) begin
        if (expq.size() == 0 || expq[0].is_done) begin
          chk("unexpected_dout_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("row_last", row_last, e.last);
          beats++;
        end
      end else if (row_last) begin
        chk("row_last_unqualified", row_last, 0);
      end
      if (done) begin
        if (expq.size() == 0 || !expq[0].is_done) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("handshakes", hs_cnt, e.rows);
          chk("busy_with_done", busy, 0);
          chk("done_after_last_beat", p_dv && p_last, 1);
        end
      end
      if (!p_rst && p_dv && !p_last) chk("dout_valid_contig", dout_valid, 1);
      if (fifo_rd_en && !p_rd) chk("row_gap_ge2", idle >= 2, 1);
      idle = fifo_rd_en ? 0 : idle + 1;
      if (!p_rst && p_vld && !p_rdy) chk("req_valid_held", req_valid, 1);
      if (!p_rst && req_valid && !p_vld) chk("req_rise_needs_s_ready", p_srdy, 1);
      if (fifo_clr) hs_cnt = 0;
      if (req_valid && req_ready) hs_cnt++;
      p_rst = 0;
    end
    p_vld  = req_valid;
    p_rdy  = req_ready;
    p_srdy = S_Ready;
    p_dv   = dout_valid;
    p_last = row_last;
    p_rd   = fifo_rd_en;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fifo_clr"}, fifo_clr, 0);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_row_last"}, row_last, 0);
  endtask

  task automatic start_layer(input int rw, input int rn);
    row_words = (AB+1)'(rw);
    row_num   = CB'(rn);
    start     = 1'b1;
    for (int r = 0; r < rn; r++)
      for (int w = 0; w < rw; w++)
        expq.push_back('{is_done: 1'b0, last: (w == rw - 1), rows: 0});
    expq.push_back('{is_done: 1'b1, last: 1'b0, rows: rn});
    tick();
    start = 1'b0;
    chk("fifo_clr_T+1", fifo_clr, 1);
    chk("busy_T+1", busy, 1);
    chk("req_valid_T+1", req_valid, 0);
    chk("M_count", M_count, rw);
    chk("S_count", S_count, rw);
    tick();
    chk("fifo_clr_one_cycle", fifo_clr, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      chk("layer_timeout", n, 0);
      expq.delete();
    end
    repeat (3) tick();
    check_quiet("after_done");
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      tick();
      n++;
    end
    chk("beats_reached", beats >= target, 1);
  endtask

  task automatic run_layer(input int rw, input int rn);
    int b0;
    b0 = beats;
    start_layer(rw, rn);
    wait_done(20000);
    chk("beat_total", beats - b0, rw * rn);
  endtask

  initial begin
    int b0, n;
    rst = 1'b1; start = 1'b0; row_words = '0; row_num = '0;
    repeat (3) tick();
    check_quiet("reset");
    chk("reset_M_count", M_count, 0);
    chk("reset_S_count", S_count, 0);
`ifdef ROUTE_READ_CTRL_ERR_EN
    chk("reset_err", err, 0);
`endif
    rst = 1'b0;
    tick();

    rr_mode = 0;
    run_layer(16, 4);

    rr_mode = 1;
    run_layer(8, 3);

    rr_mode = 0;
    b0 = beats;
    start_layer(12, 5);
    wait_beats(b0 + 12, 3000);
    s_hold = 1'b1;
    repeat (20) tick();
    s_hold = 1'b0;
    wait_done(20000);
    chk("beat_total_shold", beats - b0, 60);

    m_toggle = 1'b1;
    run_layer(10, 4);
    run_layer(1, 3);
    b0 = beats;
    start_layer(20, 3);
    repeat (15) tick();
    row_words = 5; row_num = 1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("M_count_after_ignored_start", M_count, 20);
    wait_done(20000);
    chk("beat_total_ignored_start", beats - b0, 60);
    m_toggle = 1'b0;

    b0 = beats;
    start_layer(16, 4);
    wait_beats(b0 + 16, 3000);
    n = 0;
    while (!fifo_rd_en && n < 500) begin
      tick();
      n++;
    end
    chk("row2_reading", fifo_rd_en, 1);
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    check_quiet("mid_reset");
    chk("mid_reset_M_count", M_count, 0);
    tick();
    run_layer(16, 4);

    for (int i = 0; i < 5; i++) begin
      rr_mode  = int'($urandom_range(0, 2));
      m_toggle = 1'($urandom_range(0, 1));
      run_layer(int'($urandom_range(1, 40)), int'($urandom_range(1, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/route_read_ctrl.md
# route_read_ctrl

Sequencer for the route-layer read path. It issues per-row read requests from the memory reader into the route read FIFO while the FIFO reports room. It drains the FIFO one row at a time to the concat datapath once a full row is buffered. It drives the FIFO's threshold inputs, `rd_en` and flush, and reports completion to the layer scheduler.

## Interface
Parameters:
- `WIDTH`, 128, FIFO word width (informational; passes through to datapath valid only)
- `ADDR_BITS`, 10, FIFO depth bits; thresholds are `ADDR_BITS+1` wide
- `CNT_BITS`, 12, row counter width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a layer, sampled only in IDLE
- `row_words`  in  ADDR_BITS+1  words per row (1..500), latched at start
- `row_num`  in  CNT_BITS  rows per layer (≥1), latched at start
- `busy`  out  1  high from cycle after accepted start until done
- `done`  out  1  one-cycle pulse after last word of last row
- `fifo_clr`  out  1  one-cycle FIFO flush, drives FIFO `rst` together with `rst`
- `req_valid`  out  1  row read request to memory reader
- `req_ready`  in  1  reader accepts request
- `M_count`  out  ADDR_BITS+1  back threshold = latched `row_words`
- `S_count`  out  ADDR_BITS+1  front threshold = latched `row_words`
- `M_Ready`  in  1  FIFO holds ≥ `M_count` words (registered in FIFO)
- `S_Ready`  in  1  FIFO has room (registered in FIFO)
- `fifo_rd_en`  out  1  FIFO read strobe
- `dout_valid`  out  1  FIFO `dout` valid this cycle (`fifo_rd_en` delayed 1)
- `row_last`  out  1  qualifies `dout_valid` for last word of a row

## Operation
- Front and back are independent FSMs sharing latched config.
- Front FSM: F_IDLE → F_REQ → F_HOLD → F_REQ … → F_END.
  - F_REQ: issue when `S_Ready`=1 and `req_cnt` < `row_num`; assert `req_valid`.
  - F_HOLD: hold `req_valid` stable until `req_ready`; on handshake increment `req_cnt`.
  - When `req_cnt` = `row_num`, go to F_END and stay there until back completes.
- Back FSM: B_IDLE → B_WAIT → B_READ → B_GAP → B_WAIT … → B_DONE → B_IDLE.
  - B_WAIT: on `M_Ready`=1, enter B_READ.
  - B_READ: assert `fifo_rd_en` for exactly `row_words` consecutive cycles via word counter; on the last word, increment `row_cnt`.
  - B_GAP: two cycles with no reads. This covers FIFO count and M_Ready register lag, so a stale `M_Ready` can never start a row.
  - After the last row's B_READ, go to B_DONE (1 cycle, waits for final `dout_valid`), pulse `done`, and return both FSMs to IDLE.
- Start in IDLE: latch config, pulse `fifo_clr`, zero counters; both FSMs leave IDLE the following cycle.
- `start` while `busy` is ignored.
- Counters: `req_cnt`, `row_cnt` are CNT_BITS and never wrap; comparisons are equality against latched `row_num`. Word counter is ADDR_BITS+1, with terminal count `row_words-1`.

## Timing
- Reset values: `busy`=0, `done`=0, `fifo_clr`=0, `req_valid`=0, `fifo_rd_en`=0, `dout_valid`=0, `row_last`=0. `M_count`, `S_count` reset to 0.
- `rst` mid-operation: everything returns to IDLE next cycle, and outstanding requests are abandoned. The FIFO is flushed by the shared `rst`.
- `start` at cycle T: `fifo_clr`=1 and `busy`=1 at T+1; earliest `req_valid` at T+2.
- `fifo_rd_en` at cycle t gives `dout_valid` at t+1. Inside a row, `dout_valid` is contiguous.
- `M_Ready` rising at t gives the first `fifo_rd_en` at t+1. Minimum spacing between rows is 2 idle cycles.
- `done` fires the cycle after the last `dout_valid`; `busy` falls with `done`.
- When `req_ready` and `S_Ready` drop in the same cycle that a request is pending, the handshake completes and no new request is issued.

## Configuration
- `ROUTE_READ_CTRL_ERR_EN` defined: adds output `err` (1 bit, sticky, reset 0, cleared on accepted start).
  - Set on `start` while `busy`.
  - Set on `row_words`=0 or `row_num`=0 at start; in that case, skip to done immediately.
  - Set on `M_Ready`=0 observed during B_READ (underrun).
- Undefined: no `err` port; zero-size config behaviour is undefined.

## Structure
- Package `route_ctrl_pkg`: front/back state enums, `GAP_CYCLES`=2, default widths.
- Sub-module `route_req_gen` holds the front FSM and `req_cnt`. The top holds the back FSM, config latch and done logic.

## Test plan
- `row_words`=16, `row_num`=4, reader always ready, FIFO model → 4 requests, 64 `dout_valid`, `row_last` on words 16/32/48/64, one `done`, `busy` 0 after.
- `req_ready` delayed 3 cycles per request → `req_valid` held stable, exactly `row_num` handshakes.
- `S_Ready` forced 0 for 20 cycles after row 1 → no `req_valid` during hold, resumes within 1 cycle of `S_Ready`=1.
- `M_Ready` toggled mid-run → no read starts within 2 cycles after a row ends, never more than `row_words` reads per row.
- `rst` pulsed during B_READ of row 2 → all outputs 0 next cycle, new start completes normally.
- With `ROUTE_READ_CTRL_ERR_EN`: start while busy → `err`=1, run unaffected; `row_num`=0 → `done` 2 cycles after start, `err`=1.
